// File: rtl/mmio_bus_if.sv
// Core-side memory bus between the multicycle core and mmio_bus.
// master: the core (drives strobe, address, write data).
// slave:  the decoder (returns combinational read data).
interface mmio_bus_if;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemWrite,
    output Adr,
    output WriteData,
    input  ReadData
  );

  modport slave (
    input  MemWrite,
    input  Adr,
    input  WriteData,
    output ReadData
  );
endinterface

// File: rtl/mmio_bus.sv
// mmio_bus: address decoder plus local peripherals.
// The low 256 bytes go to the RAM. 0x100-0x11F hold the following registers:
// LED, timer, and a one-byte serial transmitter.
// Optional timer block: define MMIO_TIMER_EN to build MTIME/MTIMECMP/match.
module mmio_bus #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  mmio_bus_if.slave   bus,
  output logic        ram_we,
  output logic [31:0] ram_adr,
  output logic [31:0] ram_wd,
  input  logic [31:0] ram_rd,
  output logic [7:0]  led,
  output logic        tx,
  output logic        timer_irq
);

  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Decode on word address; byte offset bits are ignored.
  logic       ram_hit;
  logic       mmio_hit;
  logic [2:0] reg_sel;
  logic       mmio_wr;
  logic       wr_led;
  logic       wr_txdata;

  assign ram_hit   = (bus.Adr[31:8] == 24'd0);
  assign mmio_hit  = (bus.Adr[31:5] == 27'd8);
  assign reg_sel   = bus.Adr[4:2];
  assign mmio_wr   = bus.MemWrite & mmio_hit;
  assign wr_led    = mmio_wr & (reg_sel == 3'd0);
  assign wr_txdata = mmio_wr & (reg_sel == 3'd4);

  // Address bits [1:0] and upper write-data bits are not needed here.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.Adr[1:0], bus.WriteData[31:8]};

  // RAM passthrough
  assign ram_adr = bus.Adr;
  assign ram_wd  = bus.WriteData;
  assign ram_we  = bus.MemWrite & ram_hit;

  // LED register
  logic [7:0] led_reg;

  // Capture the low byte of LED writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      led_reg <= 8'd0;
    end else if (wr_led) begin
      led_reg <= bus.WriteData[7:0];
    end
  end

  assign led = led_reg;

  // Timer block
  logic [31:0] mtime_rd;
  logic [31:0] mtimecmp_rd;
  logic        match_rd;

`ifdef MMIO_TIMER_EN
  logic [31:0] mtime_reg;
  logic [31:0] mtimecmp_reg;
  logic        match_reg;
  logic        wr_mtimecmp;
  logic        wr_status;

  assign wr_mtimecmp = mmio_wr & (reg_sel == 3'd2);
  assign wr_status   = mmio_wr & (reg_sel == 3'd3);

  // Free-running counter, compare register and sticky match (set beats clear).
  always_ff @(posedge clk) begin
    if (!reset) begin
      mtime_reg    <= 32'd0;
      mtimecmp_reg <= 32'hFFFF_FFFF;
      match_reg    <= 1'b0;
    end else begin
      mtime_reg <= mtime_reg + 32'd1;
      if (wr_mtimecmp) begin
        mtimecmp_reg <= bus.WriteData;
      end
      // Equality uses the compare value held before any same-edge write.
      if (mtime_reg == mtimecmp_reg) begin
        match_reg <= 1'b1;
      end else if (wr_status && bus.WriteData[1]) begin
        match_reg <= 1'b0;
      end
    end
  end

  assign mtime_rd    = mtime_reg;
  assign mtimecmp_rd = mtimecmp_reg;
  assign match_rd    = match_reg;
  assign timer_irq   = match_reg;
`else
  assign mtime_rd    = 32'd0;
  assign mtimecmp_rd = 32'd0;
  assign match_rd    = 1'b0;
  assign timer_irq   = 1'b0;
`endif

  // Serial transmitter
  tx_state_t   tx_state_reg;
  logic [15:0] tx_cnt_reg;
  logic [2:0]  tx_bit_reg;
  logic [7:0]  tx_shift_reg;
  logic        tx_reg;
  logic        tx_busy;

  assign tx_busy = (tx_state_reg != IDLE);
  assign tx      = tx_reg;

  // Frame sequencer: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_reg <= IDLE;
      tx_cnt_reg   <= 16'd0;
      tx_bit_reg   <= 3'd0;
      tx_shift_reg <= 8'd0;
      tx_reg       <= 1'b1;
    end else begin
      case (tx_state_reg)
        IDLE: begin
          // Writes while busy are ignored because only IDLE accepts them.
          if (wr_txdata) begin
            tx_shift_reg <= bus.WriteData[7:0];
            tx_cnt_reg   <= 16'd0;
            tx_reg       <= 1'b0;
            tx_state_reg <= START;
          end
        end
        START: begin
          if (tx_cnt_reg == CNT_LAST) begin
            tx_cnt_reg   <= 16'd0;
            tx_bit_reg   <= 3'd0;
            tx_reg       <= tx_shift_reg[0];
            tx_state_reg <= DATA;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 16'd1;
          end
        end
        DATA: begin
          if (tx_cnt_reg == CNT_LAST) begin
            tx_cnt_reg <= 16'd0;
            if (tx_bit_reg == 3'd7) begin
              tx_reg       <= 1'b1;
              tx_state_reg <= STOP;
            end else begin
              tx_bit_reg   <= tx_bit_reg + 3'd1;
              tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
              tx_reg       <= tx_shift_reg[1];
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 16'd1;
          end
        end
        STOP: begin
          if (tx_cnt_reg == CNT_LAST) begin
            tx_cnt_reg   <= 16'd0;
            tx_state_reg <= IDLE;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 16'd1;
          end
        end
        default: begin
          tx_state_reg <= IDLE;
          tx_reg       <= 1'b1;
        end
      endcase
    end
  end

  // Combinational read mux; unmapped and reserved locations return 0.
  always_comb begin
    bus.ReadData = 32'd0;
    if (ram_hit) begin
      bus.ReadData = ram_rd;
    end else if (mmio_hit) begin
      case (reg_sel)
        3'd0:    bus.ReadData = {24'd0, led_reg};
        3'd1:    bus.ReadData = mtime_rd;
        3'd2:    bus.ReadData = mtimecmp_rd;
        3'd3:    bus.ReadData = {30'd0, match_rd, tx_busy};
        default: bus.ReadData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus.sv
// Testbench for mmio_bus: directed scenarios followed by random traffic,
// all checked every cycle against a behavioural model of the register map.
module tb_mmio_bus;
  localparam int C = 4;
  localparam int FRAME = 10 * C;

  logic        clk = 1'b0;
  logic        reset;
  logic        ram_we;
  logic [31:0] ram_adr;
  logic [31:0] ram_wd;
  logic [31:0] ram_rd;
  logic [7:0]  led;
  logic        tx;
  logic        timer_irq;

  int n_checks = 0;
  int n_errors = 0;

  mmio_bus_if bus ();

  mmio_bus #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ram_we    (ram_we),
    .ram_adr   (ram_adr),
    .ram_wd    (ram_wd),
    .ram_rd    (ram_rd),
    .led       (led),
    .tx        (tx),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_led;
  logic [31:0] m_mtime;
  logic [31:0] m_cmp;
  logic        m_match;
  int          m_age;    // cycles since frame start; >= FRAME means idle
  logic [7:0]  m_byte;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_busy();
    return m_age < FRAME;
  endfunction

  // Expected serial line level from the position inside the frame.
  function automatic logic m_tx();
    int b;
    if (m_age >= FRAME) return 1'b1;
    b = m_age / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  function automatic logic m_irq();
`ifdef MMIO_TIMER_EN
    return m_match;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] adr, input logic [31:0] rr);
    logic [31:0] v;
    v = 32'd0;
    if (adr < 32'h100) begin
      v = rr;
    end else if (adr < 32'h120) begin
      case (adr[4:2])
        3'd0: v = {24'd0, m_led};
`ifdef MMIO_TIMER_EN
        3'd1: v = m_mtime;
        3'd2: v = m_cmp;
`endif
        3'd3: v = {30'd0, m_irq(), m_busy()};
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  task automatic model_edge(input logic rst_n, input logic we, input logic [31:0] adr,
                            input logic [31:0] wd);
    logic       hit;
    logic [2:0] sel;
    logic       new_match;
    if (!rst_n) begin
      m_led   = 8'd0;
      m_mtime = 32'd0;
      m_cmp   = 32'hFFFF_FFFF;
      m_match = 1'b0;
      m_age   = FRAME;
    end else begin
      hit = we && (adr >= 32'h100) && (adr < 32'h120);
      sel = adr[4:2];
      new_match = m_match;
      if (m_mtime == m_cmp) new_match = 1'b1;
      else if (hit && sel == 3'd3 && wd[1]) new_match = 1'b0;
      m_match = new_match;
      if (hit && sel == 3'd2) m_cmp = wd;
      m_mtime = m_mtime + 32'd1;
      if (hit && sel == 3'd0) m_led = wd[7:0];
      if (!m_busy() && hit && sel == 3'd4) begin
        m_byte = wd[7:0];
        m_age  = 0;
      end else if (m_busy()) begin
        m_age++;
      end
    end
  endtask

  // One bus cycle: drive, check combinational and state outputs, clock.
  task automatic step(input logic rst_n, input logic we, input logic [31:0] adr,
                      input logic [31:0] wd);
    reset         = rst_n;
    bus.MemWrite  = we;
    bus.Adr       = adr;
    bus.WriteData = wd;
    ram_rd        = $urandom;
    #1;
    check_val("ReadData", bus.ReadData, m_read(adr, ram_rd));
    check_val("ram_we", {31'd0, ram_we}, {31'd0, we && (adr < 32'h100)});
    check_val("ram_adr", ram_adr, adr);
    check_val("ram_wd", ram_wd, wd);
    check_val("led", {24'd0, led}, {24'd0, m_led});
    check_val("tx", {31'd0, tx}, {31'd0, m_tx()});
    check_val("timer_irq", {31'd0, timer_irq}, {31'd0, m_irq()});
    if (we) $display("write adr=%h data=%h reset=%0d", adr, wd, rst_n);
    @(posedge clk);
    model_edge(rst_n, we, adr, wd);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h10C, 32'd0);
  endtask

  initial begin
    logic [31:0] adr;
    logic [31:0] wd;
    logic        we;
    int          r;

    reset = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Adr = 32'd0;
    bus.WriteData = 32'd0;
    ram_rd = 32'd0;
    repeat (2) @(posedge clk);
    model_edge(1'b0, 1'b0, 32'd0, 32'd0);
    #1;

    // Reset state, including STATUS read while still in reset.
    step(1'b0, 1'b0, 32'h10C, 32'd0);
    check_val("reset_led", {24'd0, led}, 32'd0);
    check_val("reset_tx", {31'd0, tx}, 32'd1);

    // RAM passthrough and read-back.
    step(1'b1, 1'b1, 32'h064, 32'h19);
    step(1'b1, 1'b0, 32'h064, 32'd0);

    // LED register.
    step(1'b1, 1'b1, 32'h100, 32'hFFFF_FFA5);
    check_val("led_a5", {24'd0, led}, 32'h0000_00A5);
    step(1'b1, 1'b0, 32'h100, 32'd0);

    // Serial frame with a dropped write in the middle.
    step(1'b1, 1'b1, 32'h110, 32'h5A);
    idle(10);
    step(1'b1, 1'b1, 32'h110, 32'h33);
    idle(45);

    // Timer: match after compare write, clear, then clear on the match edge.
    step(1'b1, 1'b1, 32'h108, m_mtime + 32'd10);
    idle(12);
    step(1'b1, 1'b1, 32'h10C, 32'h2);
    idle(2);
    step(1'b1, 1'b1, 32'h108, m_mtime + 32'd3);
    idle(2);
    step(1'b1, 1'b1, 32'h10C, 32'h2);
    idle(3);
    // Compare write on the equality edge uses the old compare value.
    step(1'b1, 1'b1, 32'h10C, 32'h2);
    step(1'b1, 1'b1, 32'h108, m_mtime + 32'd2);
    step(1'b1, 1'b0, 32'h108, 32'd0);
    step(1'b1, 1'b1, 32'h108, 32'h1234);
    idle(3);

    // Unmapped and reserved addresses.
    step(1'b1, 1'b0, 32'h200, 32'd0);
    step(1'b1, 1'b0, 32'h114, 32'd0);
    step(1'b1, 1'b1, 32'h200, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 32'h114, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 32'h11C, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 32'h104, 32'hDEAD_BEEF);
    idle(2);

    // Reset in the middle of DATA, then a fresh frame.
    step(1'b1, 1'b1, 32'h110, 32'hC3);
    idle(15);
    step(1'b0, 1'b0, 32'h10C, 32'd0);
    step(1'b1, 1'b1, 32'h110, 32'h96);
    idle(FRAME);
    // Back-to-back frame on the first non-busy cycle.
    step(1'b1, 1'b1, 32'h110, 32'h01);
    idle(FRAME + 2);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      adr = $urandom_range(0, 255);
      else if (r <= 7) adr = 32'h100 + $urandom_range(0, 31);
      else if (r == 8) adr = 32'h120 + $urandom_range(0, 32'hEDF);
      else             adr = $urandom;
      we = ($urandom_range(0, 2) == 0);
      wd = $urandom;
      if (adr >= 32'h100 && adr < 32'h120 && adr[4:2] == 3'd2 && $urandom_range(0, 1) == 1)
        wd = m_mtime + $urandom_range(0, 20);
      if ($urandom_range(0, 299) == 0) step(1'b0, we, adr, wd);
      else                             step(1'b1, we, adr, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmio_bus.md
# mmio_bus

Address decoder and memory-mapped peripheral block between the multicycle RISC-V core's data/instruction port (`MemWrite`, `Adr`, `WriteData`, `ReadData`) and the unified word memory.

- Addresses `0x000`–`0x0FF` pass through to the 64-word RAM.
- Addresses `0x100`–`0x11F` hit local registers:
  - LED output register
  - free-running cycle timer with compare flag
  - one-byte serial transmitter with busy handshake
- Reads are combinational, so the core's next-edge latch of `ReadData` is unchanged. Writes take effect on the rising edge.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range 1–65535.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `MemWrite`  in  1  core write strobe.
- `Adr`  in  32  core byte address; bits [1:0] ignored.
- `WriteData`  in  32  core write data.
- `ReadData`  out  32  read data to core, combinational.
- `ram_we`  out  1  RAM write enable.
- `ram_adr`  out  32  RAM byte address.
- `ram_wd`  out  32  RAM write data.
- `ram_rd`  in  32  RAM read data.
- `led`  out  8  LED register contents.
- `tx`  out  1  serial output; idles high.
- `timer_irq`  out  1  copy of the sticky timer match flag.

## Operation

Decode uses `Adr[31:2]`:
- **RAM:** `Adr < 0x100`.
- **MMIO:** `0x100 <= Adr <= 0x11F`.
- **Unmapped:** everything else. Reads return 0; writes are dropped.

RAM passthrough:
- `ram_adr = Adr`, `ram_wd = WriteData`.
- `ram_we = MemWrite & RAM hit`.
- `ReadData = ram_rd` on a RAM hit.

Register map:
- `0x100 LED` (RW): bits [7:0]; upper bits read 0.
- `0x104 MTIME` (RO): 32-bit counter, +1 every cycle, wraps `0xFFFFFFFF` → 0. Writes ignored.
- `0x108 MTIMECMP` (RW): 32-bit compare value.
- `0x10C STATUS`:
  - bit0 `tx_busy` (RO).
  - bit1 `match` (W1C).
  - other bits read 0.
- `0x110 TXDATA` (WO): bits [7:0] are the byte to send. Reads return 0.
- `0x114`–`0x11F`: reserved; read 0, writes ignored.

Match flag:
- Set at the edge where `MTIME == MTIMECMP`.
- Cleared by writing 1 to `STATUS` bit1.
- If set and clear occur on the same edge, set wins.

Serial transmitter FSM, states `IDLE`, `START`, `DATA`, `STOP`:
- **IDLE:** `tx=1`, `busy=0`. A write to `TXDATA` loads the shift register and goes to `START`.
- **START:** `tx=0` for `CLKS_PER_BIT` cycles, then `DATA`.
- **DATA:** bits 0..7, LSB first, each held `CLKS_PER_BIT` cycles; a 3-bit index counts bits. After bit 7, go to `STOP`.
- **STOP:** `tx=1` for `CLKS_PER_BIT` cycles, then `IDLE`.
- A `TXDATA` write while `busy=1` is silently dropped; the frame in flight is not disturbed.

## Timing

- Reset (`reset=0` sampled at an edge):
  - `led=0`, `tx=1`, `timer_irq=0`, `busy=0`.
  - `MTIME=0`, `MTIMECMP=0xFFFFFFFF`, `match=0`, FSM=`IDLE`.
- Reset mid-frame aborts the frame; `tx=1` from the next cycle.
- `ReadData` and `ram_*` outputs are purely combinational from inputs and current state; zero latency.
- A register write at edge N is visible on read in cycle N+1.
- `TXDATA` write accepted at edge N:
  - `tx=0` and `busy=1` from cycle N+1.
  - Frame lasts exactly `10*CLKS_PER_BIT` cycles.
  - `busy=0` in cycle N+1+`10*CLKS_PER_BIT`.
- A write on the first cycle in which `busy` reads 0 is accepted; back-to-back frames have no gap.
- `MTIME` reads K in the K-th cycle after reset release, counting from 0.
- `match` rises the cycle after `MTIME == MTIMECMP`.
- `timer_irq` equals `match` with no extra delay.
- `MTIMECMP` write and equality on the same edge: the comparison uses the old `MTIMECMP`.

## Configuration

- `MMIO_TIMER_EN` defined: `MTIME`, `MTIMECMP`, the match flag and `timer_irq` are built as specified.
- Not defined:
  - No timer registers are synthesized.
  - `0x104` and `0x108` read 0 and ignore writes.
  - `STATUS` bit1 reads 0 and `timer_irq` is tied 0.
  - The LED and serial behaviour is unchanged.

## Test plan

- **RAM passthrough:** write `0x19` to `0x64` → `ram_we=1`, `ram_adr=0x64`, `ram_wd=0x19` in the same cycle; a read of `0x64` returns `ram_rd`; `ram_we=0` for any MMIO write.
- **LED register:** write `0xFFFF_FFA5` to `0x100` → `led=0xA5` next cycle; read returns `0x000000A5`; reset low → `led=0`.
- **Serial frame** (`CLKS_PER_BIT=4`): write `0x5A` to `0x110` → `tx` sequence 0, 0,1,0,1,1,0,1,0, 1, each bit 4 cycles; `STATUS` bit0=1 for 40 cycles, then 0; a second write during the frame is dropped (no second frame).
- **Timer match** (`MMIO_TIMER_EN`): write `MTIMECMP` = current `MTIME`+10 → `timer_irq` rises 11 cycles after the write; write `0x2` to `0x10C` → clears; a clear on the match edge leaves it set.
- **Unmapped and reserved addresses:** read `0x200` and `0x114` → 0; writes change no state and give `ram_we=0`.
- **Reset mid-frame:** assert reset during `DATA` → `tx=1`, `busy=0`, FSM in `IDLE` from the next cycle; a new `TXDATA` write after release is accepted.
